// File: rtl/keypad_matrix_scanner.sv
// ROWS_COUNT x COLS_COUNT keypad scanner: one-hot column drive, press/release debounce,
// {row_idx,col_idx} encoding and valid/ack handshake. Define KEYPAD_AUTOREPEAT_EN for held-key repeat.
module keypad_matrix_scanner #(
  parameter int unsigned ROWS_COUNT      = 4,
  parameter int unsigned COLS_COUNT      = 4,
  parameter int unsigned SCAN_DIV        = 16,
`ifdef KEYPAD_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY    = 4096,
  parameter int unsigned REPEAT_PERIOD   = 1024,
`endif
  parameter int unsigned DEBOUNCE_CYCLES = 64
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [ROWS_COUNT-1:0]                            rows,
  input  logic                                             ack,
  output logic [COLS_COUNT-1:0]                            cols,
  output logic [ROWS_COUNT+COLS_COUNT-1:0]                 data,
  output logic [$clog2(ROWS_COUNT)+$clog2(COLS_COUNT)-1:0] code,
  output logic                                             valid,
  output logic                                             multi_err
);

  localparam int unsigned RW  = $clog2(ROWS_COUNT);
  localparam int unsigned CW  = $clog2(COLS_COUNT);
  localparam int unsigned DVW = $clog2(SCAN_DIV);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  typedef enum logic [2:0] {S_SCAN, S_DEBOUNCE, S_REPORT, S_RELEASE, S_REPEAT} state_t;
`else
  typedef enum logic [2:0] {S_SCAN, S_DEBOUNCE, S_REPORT, S_RELEASE} state_t;
`endif

  state_t                 state;
  logic [DVW-1:0]         dwell;
  logic [DBW-1:0]         cnt;
  logic [ROWS_COUNT-1:0]  pattern;

  function automatic logic [RW-1:0] row_index(input logic [ROWS_COUNT-1:0] v);
    row_index = '0;
    for (int unsigned i = 0; i < ROWS_COUNT; i++)
      if (v[i]) row_index = RW'(i);
  endfunction

  function automatic logic [CW-1:0] col_index(input logic [COLS_COUNT-1:0] v);
    col_index = '0;
    for (int unsigned i = 0; i < COLS_COUNT; i++)
      if (v[i]) col_index = CW'(i);
  endfunction

  function automatic logic [COLS_COUNT-1:0] rotl(input logic [COLS_COUNT-1:0] v);
    rotl = {v[COLS_COUNT-2:0], v[COLS_COUNT-1]};
  endfunction

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPW     = $clog2(RPT_MAX + 1);

  logic [RPW-1:0] rpt_cnt;
  logic           rpt_first;
  logic [RPW-1:0] rpt_limit_c;
  logic           single_c;

  // First repeat waits the long delay, later ones the period
  assign rpt_limit_c = rpt_first ? RPW'(REPEAT_DELAY - 1) : RPW'(REPEAT_PERIOD - 1);
  assign single_c    = ($countones(pattern) == 1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_SCAN;
      cols      <= COLS_COUNT'(1);
      data      <= '0;
      code      <= '0;
      valid     <= 1'b0;
      multi_err <= 1'b0;
      dwell     <= '0;
      cnt       <= '0;
      pattern   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      multi_err <= 1'b0;
      case (state)
        S_SCAN: begin
          if (!start) begin
            dwell <= '0;
          end else if (dwell == DVW'(SCAN_DIV - 1)) begin
            dwell <= '0;
            if (rows == '0) begin
              cols <= rotl(cols);
            end else begin
              pattern <= rows;
              cnt     <= '0;
              state   <= S_DEBOUNCE;
            end
          end else begin
            dwell <= dwell + DVW'(1);
          end
        end

        // Extra cycle past the last match gives DEBOUNCE_CYCLES+1 latency from the sample edge
        S_DEBOUNCE: begin
          if (rows != pattern) begin
            dwell <= '0;
            state <= S_SCAN;
          end else if (cnt == DBW'(DEBOUNCE_CYCLES)) begin
            cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
            if ($countones(pattern) == 1) begin
              data  <= {pattern, cols};
              code  <= {row_index(pattern), col_index(cols)};
              valid <= 1'b1;
              state <= S_REPORT;
            end else begin
              multi_err <= 1'b1;
              state     <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + DBW'(1);
          end
        end

        S_REPORT: begin
          if (ack) begin
            valid <= 1'b0;
            cnt   <= '0;
            state <= S_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end
        end

        S_RELEASE: begin
          if (rows != '0) begin
            cnt <= '0;
          end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            dwell <= '0;
            cols  <= rotl(cols);
            state <= S_SCAN;
          end else begin
            cnt <= cnt + DBW'(1);
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (single_c && (rows == pattern)) begin
            if (rpt_cnt == rpt_limit_c) begin
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
              valid     <= 1'b1;
              state     <= S_REPEAT;
            end else begin
              rpt_cnt <= rpt_cnt + RPW'(1);
            end
          end else begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end
`endif
        end

`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer keeps running while waiting for ack; a repeat due now is dropped
        S_REPEAT: begin
          cnt <= '0;
          if (ack) begin
            valid <= 1'b0;
            state <= S_RELEASE;
          end
          if (rows == pattern) begin
            if (rpt_cnt == rpt_limit_c) begin
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + RPW'(1);
            end
          end else begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end
        end
`endif

        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (4x4, SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// Repeat timing is checked when built with KEYPAD_AUTOREPEAT_EN.
module tb_keypad_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] rows;
  logic       ack;
  logic [3:0] cols;
  logic [7:0] data;
  logic [3:0] code;
  logic       valid;
  logic       multi_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS_COUNT     (4),
    .COLS_COUNT     (4),
    .SCAN_DIV       (4),
`ifdef KEYPAD_AUTOREPEAT_EN
    .REPEAT_DELAY   (32),
    .REPEAT_PERIOD  (16),
`endif
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rows     (rows),
    .ack      (ack),
    .cols     (cols),
    .data     (data),
    .code     (code),
    .valid    (valid),
    .multi_err(multi_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cols(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (cols !== target && n < 64) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(cols), 32'(target));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic [3:0] c0;
    logic [3:0] c0_rot;
    int         merr_cnt;
    int         n;

    rst = 1'b0; start = 1'b0; ack = 1'b0; rows = 4'b0000;
    tick(2);
    chk("reset_cols",  32'(cols),      32'h1);
    chk("reset_valid", 32'(valid),     32'h0);
    chk("reset_data",  32'(data),      32'h0);
    chk("reset_code",  32'(code),      32'h0);
    chk("reset_merr",  32'(multi_err), 32'h0);

    // Press row2 on col1: sample 4 edges after col1 appears, valid 9 edges later
    rst = 1'b1; start = 1'b1;
    wait_cols(4'b0010, "press_reach_col1");
    rows = 4'b0100;
    tick(12);
    chk("press_valid_early", 32'(valid), 32'h0);
    tick(1);
    chk("press_valid_rise", 32'(valid), 32'h1);
    chk("press_data",       32'(data),  32'h42);
    chk("press_code",       32'(code),  32'h9);
    chk("press_cols_held",  32'(cols),  32'h2);
    tick(20);
    chk("press_valid_held", 32'(valid), 32'h1);
    chk("press_data_held",  32'(data),  32'h42);

    // Asynchronous reset in the middle of a report
    #1 rst = 1'b0;
    #1;
    chk("midrst_cols",  32'(cols),  32'h1);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_data",  32'(data),  32'h0);
    chk("midrst_code",  32'(code),  32'h0);
    rows = 4'b0000;
    tick(1);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen), 32'h0);

    // Handshake, held key, then release advances the column
    wait_cols(4'b0010, "hs_reach_col1");
    rows = 4'b0100;
    wait_valid("hs_valid");
    chk("hs_code", 32'(code), 32'h9);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("hs_ack_clears", 32'(valid), 32'h0);
    seen = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int i = 0; i < 20; i++) begin
`else
    for (int i = 0; i < 100; i++) begin
`endif
      tick(1);
      if (valid) seen = 1'b1;
    end
    chk("hs_no_second_valid", 32'(seen), 32'h0);
    rows = 4'b0000;
    tick(7);
    chk("hs_release_hold", 32'(cols), 32'h2);
    tick(1);
    chk("hs_release_adv",  32'(cols), 32'h4);
    chk("hs_data_kept",    32'(data), 32'h42);

    // Bouncing contact never completes debounce
    seen = 1'b0;
    merr_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      rows = (((i / 3) % 2) == 0) ? 4'b0100 : 4'b0000;
      tick(1);
      if (valid) seen = 1'b1;
      if (multi_err) merr_cnt++;
    end
    chk("bounce_no_valid", 32'(seen),     32'h0);
    chk("bounce_no_merr",  32'(merr_cnt), 32'h0);
    rows = 4'b0000;
    c0 = cols;
    c0_rot = {c0[2:0], c0[3]};
    n = 0;
    while (cols === c0 && n < 16) begin
      tick(1);
      n++;
    end
    chk("bounce_resume_rotate", 32'(cols), 32'(c0_rot));

    // Two rows in one column: single multi_err pulse, no report
    wait_cols(4'b1000, "multi_reach_col3");
    rows = 4'b0101;
    seen = 1'b0;
    merr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (valid) seen = 1'b1;
      if (multi_err) merr_cnt++;
    end
    chk("multi_pulse_once", 32'(merr_cnt), 32'd1);
    chk("multi_no_valid",   32'(seen),     32'h0);
    chk("multi_cols_held",  32'(cols),     32'h8);
    rows = 4'b0000;
    tick(7);
    chk("multi_release_hold", 32'(cols), 32'h8);
    tick(1);
    chk("multi_wrap_col0", 32'(cols), 32'h1);
    chk("multi_data_kept", 32'(data), 32'h42);
    chk("multi_code_kept", 32'(code), 32'h9);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Held key: first repeat 32 cycles after the ack, then every 16 cycles
    wait_cols(4'b0001, "rpt_reach_col0");
    rows = 4'b0001;
    wait_valid("rpt_valid");
    chk("rpt_code", 32'(code), 32'h0);
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      n = 1;
      while (valid !== 1'b1 && n < 100) begin
        tick(1);
        n++;
      end
      chk("rpt_interval", 32'(n), (k == 0) ? 32'd33 : 32'd16);
      chk("rpt_data", 32'(data), 32'h11);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    rows = 4'b0000;
    tick(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
